// File: rtl/sram_arb_pkg.sv
// Shared definitions for the dual-SRAM arbiter: address windows, bank FSM states, requester IDs.
package sram_arb_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h8000_0000;
  localparam logic [31:0] EXT_ADDR_DEF  = 32'h8040_0000;
  localparam int          WIN_LSB       = 22;  // 4 MiB windows
  localparam int          RAM_AW        = 20;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} bank_state_e;
  typedef enum logic {REQ_IF = 1'b0, REQ_MEM = 1'b1} req_id_e;

  function automatic logic win_hit(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:WIN_LSB] == base[31:WIN_LSB];
  endfunction

endpackage

// File: rtl/sram_bank_ctrl.sv
// One SRAM bank: grant between fetch and mem, IDLE/SETUP/STROBE/DONE sequencing, registered pin drive.
// SRAM_ARB_RR_EN selects round-robin conflict resolution instead of fixed mem-over-fetch priority.
module sram_bank_ctrl
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk_10M,
  input  logic              reset_of_clk10M,
  input  logic              if_req_i,
  input  logic [RAM_AW-1:0] if_addr_i,
  input  logic              mem_req_i,
  input  logic [RAM_AW-1:0] mem_addr_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_be_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              ack_o,
  output req_id_e           owner_o,
  output logic [31:0]       rdata_o,
  input  logic [31:0]       ram_din_i,
  output logic [31:0]       ram_dout_o,
  output logic              ram_dq_oe_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [3:0]        ram_be_n_o,
  output logic              ram_ce_n_o,
  output logic              ram_oe_n_o,
  output logic              ram_we_n_o
);

  localparam logic [2:0] WC = 3'(WAIT_CYCLES);

  bank_state_e       state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  req_id_e           owner_q, owner_d, gnt_id;
  logic              wr_q, wr_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [3:0]        be_n_q, be_n_d;
  logic [31:0]       dout_q, dout_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, dq_oe_q, dq_oe_d;
  logic              busy;
`ifdef SRAM_ARB_RR_EN
  req_id_e           prio_q, prio_d;
`endif

  always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
    if (reset_of_clk10M) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      owner_q <= REQ_MEM;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= 32'h0;
      addr_q  <= '0;
      be_n_q  <= 4'hF;
      dout_q  <= 32'h0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      prio_q  <= REQ_MEM;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      be_n_q  <= be_n_d;
      dout_q  <= dout_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dq_oe_q <= dq_oe_d;
`ifdef SRAM_ARB_RR_EN
      prio_q  <= prio_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    be_n_d  = be_n_q;
    dout_d  = dout_q;
`ifdef SRAM_ARB_RR_EN
    prio_d  = prio_q;
    if (mem_req_i && if_req_i) gnt_id = prio_q;
    else                       gnt_id = mem_req_i ? REQ_MEM : REQ_IF;
`else
    gnt_id  = mem_req_i ? REQ_MEM : REQ_IF;
`endif
    case (state_q)
      IDLE: begin
        // The ack cycle is skipped so the just-served requester cannot be re-granted.
        if (!ack_q && (if_req_i || mem_req_i)) begin
          state_d = SETUP;
          owner_d = gnt_id;
          wr_d    = (gnt_id == REQ_MEM) && mem_we_i;
          addr_d  = (gnt_id == REQ_MEM) ? mem_addr_i : if_addr_i;
          be_n_d  = ((gnt_id == REQ_MEM) && mem_we_i) ? ~mem_be_i : 4'h0;
          if ((gnt_id == REQ_MEM) && mem_we_i) dout_d = mem_wdata_i;
`ifdef SRAM_ARB_RR_EN
          if (mem_req_i && if_req_i) prio_d = (gnt_id == REQ_MEM) ? REQ_IF : REQ_MEM;
`endif
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = 3'd1;
      end
      STROBE: begin
        if (cnt_q >= WC) state_d = DONE;
        else             cnt_d   = cnt_q + 3'd1;
      end
      DONE: begin
        state_d = IDLE;
        be_n_d  = 4'hF;
      end
      default: state_d = IDLE;
    endcase

    busy    = (state_d != IDLE);
    ce_n_d  = !busy;
    oe_n_d  = !(busy && !wr_d);
    we_n_d  = !((state_d == STROBE) && wr_d);
    dq_oe_d = busy && wr_d;
    ack_d   = (state_q == DONE);
    rdata_d = ((state_q == DONE) && !wr_q) ? ram_din_i : 32'h0;
  end

  assign ack_o       = ack_q;
  assign owner_o     = owner_q;
  assign rdata_o     = rdata_q;
  assign ram_dout_o  = dout_q;
  assign ram_dq_oe_o = dq_oe_q;
  assign ram_addr_o  = addr_q;
  assign ram_be_n_o  = be_n_q;
  assign ram_ce_n_o  = ce_n_q;
  assign ram_oe_n_o  = oe_n_q;
  assign ram_we_n_o  = we_n_q;

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares BaseRAM/ExtRAM between fetch and data ports: decode, unmapped responder, ack/rdata muxing.
// Conflict policy set by SRAM_ARB_RR_EN inside sram_bank_ctrl (default: mem over fetch).
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter logic [31:0] EXT_ADDR    = EXT_ADDR_DEF
) (
  input  logic        clk_10M,
  input  logic        reset_of_clk10M,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic        mem_we,
  input  logic [3:0]  mem_be,
  input  logic [31:0] mem_wdata,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  input  logic [31:0] base_ram_din,
  input  logic [31:0] ext_ram_din,
  output logic [31:0] base_ram_dout,
  output logic [31:0] ext_ram_dout,
  output logic        base_ram_dq_oe,
  output logic        ext_ram_dq_oe,
  output logic [19:0] base_ram_addr,
  output logic [19:0] ext_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic [3:0]  ext_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        ext_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        ext_ram_oe_n,
  output logic        base_ram_we_n,
  output logic        ext_ram_we_n
);

  logic    if_base, if_ext, mem_base, mem_ext;
  logic    if_unm_q, mem_unm_q;
  logic    base_ack, ext_ack;
  req_id_e base_owner, ext_owner;
  logic [31:0] base_rdata, ext_rdata;
  logic    unused_addr_bits;

  assign if_base  = win_hit(if_addr, BASE_ADDR);
  assign if_ext   = win_hit(if_addr, EXT_ADDR);
  assign mem_base = win_hit(mem_addr, BASE_ADDR);
  assign mem_ext  = win_hit(mem_addr, EXT_ADDR);
  assign unused_addr_bits = ^{if_addr[1:0], mem_addr[1:0]};

  // Unmapped accesses answer one cycle after req; the !_q term keeps it to a single pulse.
  always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
    if (reset_of_clk10M) begin
      if_unm_q  <= 1'b0;
      mem_unm_q <= 1'b0;
    end else begin
      if_unm_q  <= if_req && !if_base && !if_ext && !if_unm_q;
      mem_unm_q <= mem_req && !mem_base && !mem_ext && !mem_unm_q;
    end
  end

  sram_bank_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) u_base (
    .clk_10M, .reset_of_clk10M,
    .if_req_i(if_req && if_base), .if_addr_i(if_addr[21:2]),
    .mem_req_i(mem_req && mem_base), .mem_addr_i(mem_addr[21:2]),
    .mem_we_i(mem_we), .mem_be_i(mem_be), .mem_wdata_i(mem_wdata),
    .ack_o(base_ack), .owner_o(base_owner), .rdata_o(base_rdata),
    .ram_din_i(base_ram_din), .ram_dout_o(base_ram_dout), .ram_dq_oe_o(base_ram_dq_oe),
    .ram_addr_o(base_ram_addr), .ram_be_n_o(base_ram_be_n), .ram_ce_n_o(base_ram_ce_n),
    .ram_oe_n_o(base_ram_oe_n), .ram_we_n_o(base_ram_we_n)
  );

  sram_bank_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) u_ext (
    .clk_10M, .reset_of_clk10M,
    .if_req_i(if_req && if_ext), .if_addr_i(if_addr[21:2]),
    .mem_req_i(mem_req && mem_ext), .mem_addr_i(mem_addr[21:2]),
    .mem_we_i(mem_we), .mem_be_i(mem_be), .mem_wdata_i(mem_wdata),
    .ack_o(ext_ack), .owner_o(ext_owner), .rdata_o(ext_rdata),
    .ram_din_i(ext_ram_din), .ram_dout_o(ext_ram_dout), .ram_dq_oe_o(ext_ram_dq_oe),
    .ram_addr_o(ext_ram_addr), .ram_be_n_o(ext_ram_be_n), .ram_ce_n_o(ext_ram_ce_n),
    .ram_oe_n_o(ext_ram_oe_n), .ram_we_n_o(ext_ram_we_n)
  );

  always_comb begin
    if_ack    = (base_ack && base_owner == REQ_IF) || (ext_ack && ext_owner == REQ_IF) || if_unm_q;
    mem_ack   = (base_ack && base_owner == REQ_MEM) || (ext_ack && ext_owner == REQ_MEM) || mem_unm_q;
    if_err    = if_unm_q;
    mem_err   = mem_unm_q;
    if_rdata  = 32'h0;
    mem_rdata = 32'h0;
    if (base_ack && base_owner == REQ_IF)       if_rdata = base_rdata;
    else if (ext_ack && ext_owner == REQ_IF)    if_rdata = ext_rdata;
    if (base_ack && base_owner == REQ_MEM)      mem_rdata = base_rdata;
    else if (ext_ack && ext_owner == REQ_MEM)   mem_rdata = ext_rdata;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter at WAIT_CYCLES=1: reads, writes, conflicts, unmapped, reset abort.
module tb_sram_bus_arbiter;

  logic        clk_10M = 1'b0;
  logic        reset_of_clk10M;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        if_ack, if_err, mem_ack, mem_err;
  logic [31:0] if_rdata, mem_rdata;
  logic [31:0] base_ram_din, ext_ram_din, base_ram_dout, ext_ram_dout;
  logic        base_ram_dq_oe, ext_ram_dq_oe;
  logic [19:0] base_ram_addr, ext_ram_addr;
  logic [3:0]  base_ram_be_n, ext_ram_be_n;
  logic        base_ram_ce_n, ext_ram_ce_n, base_ram_oe_n, ext_ram_oe_n;
  logic        base_ram_we_n, ext_ram_we_n;

  int n_assert = 0;
  int n_fail   = 0;

  sram_bus_arbiter dut (
    .clk_10M(clk_10M), .reset_of_clk10M(reset_of_clk10M),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .base_ram_din(base_ram_din), .ext_ram_din(ext_ram_din),
    .base_ram_dout(base_ram_dout), .ext_ram_dout(ext_ram_dout),
    .base_ram_dq_oe(base_ram_dq_oe), .ext_ram_dq_oe(ext_ram_dq_oe),
    .base_ram_addr(base_ram_addr), .ext_ram_addr(ext_ram_addr),
    .base_ram_be_n(base_ram_be_n), .ext_ram_be_n(ext_ram_be_n),
    .base_ram_ce_n(base_ram_ce_n), .ext_ram_ce_n(ext_ram_ce_n),
    .base_ram_oe_n(base_ram_oe_n), .ext_ram_oe_n(ext_ram_oe_n),
    .base_ram_we_n(base_ram_we_n), .ext_ram_we_n(ext_ram_we_n)
  );

  always #5 clk_10M = ~clk_10M;

  task automatic step();
    @(posedge clk_10M);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_of_clk10M = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_addr = 32'h0; mem_we = 1'b0; mem_be = 4'h0; mem_wdata = 32'h0;
    base_ram_din = 32'h0; ext_ram_din = 32'h0;
    step(); step();
    chk("rst_if_ack",  32'(if_ack), 32'd0);
    chk("rst_mem_ack", 32'(mem_ack), 32'd0);
    chk("rst_if_err",  32'(if_err), 32'd0);
    chk("rst_ce_n",    32'({base_ram_ce_n, ext_ram_ce_n}), 32'h3);
    chk("rst_oe_we_n", 32'({base_ram_oe_n, base_ram_we_n}), 32'h3);
    chk("rst_dq_oe",   32'(base_ram_dq_oe), 32'd0);
    chk("rst_addr",    32'(base_ram_addr), 32'd0);
    chk("rst_be_n",    32'(base_ram_be_n), 32'hF);
    reset_of_clk10M = 1'b0;
    step();

    // Fetch read from BaseRAM
    if_req = 1'b1; if_addr = 32'h8000_0010; base_ram_din = 32'hDEADBEEF;
    step();
    chk("rd_addr", 32'(base_ram_addr), 32'h4);
    chk("rd_ce_oe_n", 32'({base_ram_ce_n, base_ram_oe_n}), 32'h0);
    chk("rd_be_n", 32'(base_ram_be_n), 32'h0);
    chk("rd_ack_c1", 32'(if_ack), 32'd0);
    step(); step();
    chk("rd_ack_c3", 32'(if_ack), 32'd0);
    step();
    chk("rd_ack_c4", 32'(if_ack), 32'd1);
    chk("rd_data", if_rdata, 32'hDEADBEEF);
    chk("rd_err", 32'(if_err), 32'd0);
    chk("rd_ce_n_c4", 32'(base_ram_ce_n), 32'd1);
    if_req = 1'b0;
    step();
    chk("rd_ack_c5", 32'(if_ack), 32'd0);

    // mem write to ExtRAM
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8040_0008; mem_be = 4'b0011; mem_wdata = 32'h12345678;
    step();
    chk("wr_addr", 32'(ext_ram_addr), 32'h2);
    chk("wr_be_n", 32'(ext_ram_be_n), 32'hC);
    chk("wr_setup_pins", 32'({ext_ram_dq_oe, ext_ram_we_n, ext_ram_oe_n, ext_ram_ce_n}), 32'b1110);
    chk("wr_dout", ext_ram_dout, 32'h12345678);
    step();
    chk("wr_strobe_pins", 32'({ext_ram_dq_oe, ext_ram_we_n, ext_ram_ce_n}), 32'b100);
    step();
    chk("wr_done_pins", 32'({ext_ram_dq_oe, ext_ram_we_n, ext_ram_ce_n}), 32'b110);
    chk("wr_ack_c3", 32'(mem_ack), 32'd0);
    chk("wr_base_idle", 32'(base_ram_ce_n), 32'd1);
    step();
    chk("wr_ack_c4", 32'(mem_ack), 32'd1);
    chk("wr_idle_pins", 32'({ext_ram_dq_oe, ext_ram_ce_n}), 32'b01);
    mem_req = 1'b0; mem_we = 1'b0;
    step();

    // Same-bank conflict on BaseRAM
    if_req = 1'b1; if_addr = 32'h8000_0020;
    mem_req = 1'b1; mem_addr = 32'h8000_0100; mem_be = 4'hF; base_ram_din = 32'hCAFEF00D;
    for (int c = 1; c <= 10; c++) begin
      step();
      chk($sformatf("cf1_mem_ack_c%0d", c), 32'(mem_ack), 32'(c == 4));
      chk($sformatf("cf1_if_ack_c%0d", c), 32'(if_ack), 32'(c == 9));
      if (c == 1) chk("cf1_addr_mem", 32'(base_ram_addr), 32'h40);
      if (c == 4) begin
        chk("cf1_mem_data", mem_rdata, 32'hCAFEF00D);
        mem_req = 1'b0;
        base_ram_din = 32'h0BADC0DE;
      end
      if (c == 6) chk("cf1_addr_if", 32'(base_ram_addr), 32'h8);
      if (c == 9) begin
        chk("cf1_if_data", if_rdata, 32'h0BADC0DE);
        if_req = 1'b0;
      end
    end

    // Second conflict: round-robin hands it to fetch, fixed priority keeps mem first
    if_req = 1'b1; mem_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
`ifdef SRAM_ARB_RR_EN
      chk($sformatf("cf2_if_ack_c%0d", c), 32'(if_ack), 32'(c == 4));
      chk($sformatf("cf2_mem_ack_c%0d", c), 32'(mem_ack), 32'(c == 9));
      if (c == 4) if_req = 1'b0;
      if (c == 9) mem_req = 1'b0;
`else
      chk($sformatf("cf2_mem_ack_c%0d", c), 32'(mem_ack), 32'(c == 4));
      chk($sformatf("cf2_if_ack_c%0d", c), 32'(if_ack), 32'(c == 9));
      if (c == 4) mem_req = 1'b0;
      if (c == 9) if_req = 1'b0;
`endif
    end

    // Different banks in parallel
    if_req = 1'b1; if_addr = 32'h8000_0004; base_ram_din = 32'h33334444;
    mem_req = 1'b1; mem_addr = 32'h8040_0004; ext_ram_din = 32'h11112222;
    step(); step(); step();
    chk("par_acks_c3", 32'({if_ack, mem_ack}), 32'b00);
    step();
    chk("par_acks_c4", 32'({if_ack, mem_ack}), 32'b11);
    chk("par_if_data", if_rdata, 32'h33334444);
    chk("par_mem_data", mem_rdata, 32'h11112222);
    if_req = 1'b0; mem_req = 1'b0;
    step();

    // Unmapped mem read
    mem_req = 1'b1; mem_addr = 32'h0000_1000;
    step();
    chk("unm_ack_err", 32'({mem_ack, mem_err}), 32'b11);
    chk("unm_rdata", mem_rdata, 32'h0);
    chk("unm_ce_n", 32'({base_ram_ce_n, ext_ram_ce_n}), 32'b11);
    mem_req = 1'b0;
    step();
    chk("unm_ack_c2", 32'({mem_ack, mem_err}), 32'b00);
    step();

    // Reset during STROBE of a write
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0040; mem_be = 4'hF; mem_wdata = 32'hAAAA5555;
    step(); step();
    chk("abort_strobe_we_n", 32'(base_ram_we_n), 32'd0);
    #2 reset_of_clk10M = 1'b1;
    #1;
    chk("abort_pins", 32'({base_ram_we_n, base_ram_ce_n, base_ram_dq_oe}), 32'b110);
    mem_req = 1'b0; mem_we = 1'b0;
    step();
    reset_of_clk10M = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("abort_no_ack_%0d", c), 32'(mem_ack), 32'd0);
    end
    if_req = 1'b1; if_addr = 32'h8000_0008; base_ram_din = 32'h5A5A5A5A;
    step();
    chk("post_rst_addr", 32'(base_ram_addr), 32'h2);
    step(); step(); step();
    chk("post_rst_ack", 32'(if_ack), 32'd1);
    chk("post_rst_data", if_rdata, 32'h5A5A5A5A);
    if_req = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares the two on-board SRAMs (BaseRAM, ExtRAM) between the CPU instruction-fetch port and the data-memory port.
- Sequences each SRAM through a multi-cycle access, decodes addresses to banks and arbitrates same-bank conflicts.
- Returns one-cycle acknowledges to the CPU.
- Sits between the CPU core and the board-level SRAM pins; tri-state buffers stay in the top level.

Parameters:
- WAIT_CYCLES, 1, number of strobe cycles per SRAM access (1..7).
- BASE_ADDR, 32'h8000_0000, start of BaseRAM window (4 MiB).
- EXT_ADDR, 32'h8040_0000, start of ExtRAM window (4 MiB).

Ports:
- clk_10M  in  1  system clock.
- reset_of_clk10M  in  1  reset.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  32  fetch byte address, word-aligned.
- if_ack  out  1  one-cycle completion pulse.
- if_rdata  out  32  fetch data, valid with if_ack.
- if_err  out  1  unmapped address, valid with if_ack.
- mem_req  in  1  data request, held until mem_ack.
- mem_addr  in  32  data byte address.
- mem_we  in  1  1 = write.
- mem_be  in  4  byte enables, active high.
- mem_wdata  in  32  write data.
- mem_ack  out  1  completion pulse.
- mem_rdata  out  32  read data, valid with mem_ack.
- mem_err  out  1  unmapped address, valid with mem_ack.
- base_ram_din / ext_ram_din  in  32  SRAM read data.
- base_ram_dout / ext_ram_dout  out  32  SRAM write data.
- base_ram_dq_oe / ext_ram_dq_oe  out  1  top-level tri-state enable.
- base_ram_addr / ext_ram_addr  out  20  SRAM word address.
- base_ram_be_n / ext_ram_be_n  out  4  byte enables, active low.
- base_ram_ce_n / ext_ram_ce_n  out  1  chip enable, active low.
- base_ram_oe_n / ext_ram_oe_n  out  1  output enable, active low.
- base_ram_we_n / ext_ram_we_n  out  1  write enable, active low.

Behaviour:
- Clock and reset: clk_10M; reset reset_of_clk10M, asynchronous, active-high.
- Reset values: all acks and errs 0; rdata 0; ce_n, oe_n, we_n all 1; dq_oe 0; addr 0; be_n 4'hF; both bank FSMs in IDLE. A reset mid-access aborts it immediately and no ack is issued.
- Decode: bank = addr[22] within 0x8000_0000..0x807F_FFFF. SRAM addr = addr[21:2]. Any other address is unmapped.
- Unmapped access: ack and err both 1 exactly one cycle after req is first seen; rdata 32'h0; no SRAM activity; no write side effects.
- Bank FSM, one per bank:
  - IDLE: grant is latched on the requester. On grant, go to SETUP; addr and be_n are latched.
  - SETUP, 1 cycle: ce_n=0. For reads, oe_n=0 and be_n=0. For writes, dq_oe=1, dout=wdata, be_n=~mem_be.
  - STROBE, WAIT_CYCLES cycles: for writes, we_n=0.
  - DONE, 1 cycle: we_n=1, ce_n still 0, dq_oe held for writes (data hold). For reads, din is registered into rdata. The granted requester's ack is pulsed in the following cycle. The FSM returns to IDLE.
- Latency: req seen in IDLE at cycle 0 gives ack in cycle 3+WAIT_CYCLES (4 at default). Back-to-back accesses insert one IDLE cycle.
- Arbitration:
  - Different banks: served concurrently.
  - Same bank, both requesting in IDLE: mem wins; fetch waits in its req-held state.
  - A grant is never preempted.
- Requester rules: req, addr, we, be and wdata must stay stable until ack. Changes before ack are undefined. Deasserting req before ack is undefined.
- The fetch port never writes; its be_n is always 4'h0.
- No combinational path from any req to any SRAM pin; all SRAM outputs are registered.

Optional Feature:
- Macro SRAM_ARB_RR_EN.
  - Defined: same-bank conflicts use a per-bank round-robin pointer. The pointer toggles to the non-winning requester after each granted conflict; reset value favours mem.
  - Undefined: fixed priority, mem over fetch.

Decomposition:
- Shared package sram_arb_pkg holds:
  - bank/address-window constants;
  - the FSM state enum (IDLE, SETUP, STROBE, DONE);
  - the requester ID encoding (REQ_IF, REQ_MEM).
- One natural sub-module: sram_bank_ctrl.
  - Contains one FSM, the grant logic and the pin drive.
  - Instantiated twice (base, ext).
  - Top level holds decode, unmapped responder and ack/rdata muxing.

Test Plan:
- Fetch read at 0x8000_0010 with base_ram_din=32'hDEADBEEF → base_ram_addr=20'h4, oe_n low, if_ack on cycle 4, if_rdata=32'hDEADBEEF, if_err=0.
- mem write 0x8040_0008, be=4'b0011, wdata=32'h12345678 → ext_ram_addr=20'h2, be_n=4'b1100, we_n low exactly 1 cycle, dq_oe spans SETUP..DONE, mem_ack on cycle 4.
- Fetch and mem both to BaseRAM in the same cycle → mem acked at cycle 4, fetch acked at cycle 9. With SRAM_ARB_RR_EN, a second simultaneous conflict grants fetch first.
- Fetch to BaseRAM and mem to ExtRAM simultaneously → both acks on cycle 4.
- mem read 0x0000_1000 → mem_ack=1, mem_err=1, mem_rdata=0 at cycle 1; all ce_n remain 1.
- Reset asserted during STROBE of a write → we_n, ce_n = 1 and dq_oe = 0 in the same cycle; no ack; after release, a new read completes normally.
